leds_pwm_driver: RTL
====================

Name: leds_pwm_driver

Overview:
- Consumes the `leds_val` vector from the LED register block and drives the physical LED pins.
- Applies global PWM brightness dimming; a bus-visible control word sets brightness and a global enable.
- Sits between the LED register and the top-level pin outputs, on the same `data_m` bus with its own chip select.

Parameters:
- NUM_LEDS, 8, number of LED channels; must equal the width of `leds_val`.
- PRESCALE_DIV, 64, clk cycles per PWM step; legal range 2..65535.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- leds_val  input  NUM_LEDS  requested LED on/off state from the LED register.
- led_pins  output  NUM_LEDS  registered pin drive, 1 = lit.
- cs  input  1  chip select for the control word.
- data_m_data_in  input  16  bus write data.
- data_m_data_out  output  16  bus read data.
- data_m_access  input  1  bus access strobe.
- data_m_ack  output  1  bus acknowledge.
- data_m_wr_en  input  1  write enable.
- data_m_bytesel  input  2  byte lane enables.

Behaviour:
- Reset (reset==0 at a clk edge) takes priority over every other event:
  - led_pins=0, data_m_ack=0, data_m_data_out=0.
  - brightness=8'hFF, shadow brightness=8'hFF, enable=1.
  - Prescaler and pwm_cnt are cleared to 0.
- Control word:
  - Bits [7:0] are brightness; bit [8] is enable; bits [15:9] read as 0 and ignore writes.
- Bus writes:
  - A write occurs when cs && data_m_access && data_m_wr_en.
  - bytesel[0] updates brightness; bytesel[1] updates enable.
- Bus reads and acknowledge:
  - data_m_ack is registered and equals cs&&data_m_access from the previous cycle.
  - data_m_data_out is registered: the control word when cs&&data_m_access, else 16'h0.
  - A held access produces ack on every cycle.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1. `tick` = (prescaler==PRESCALE_DIV-1), and the counter wraps to 0 on tick.
  - pwm_cnt (8 bits) increments on tick and wraps 255→0.
- Period boundary and shadow brightness:
  - The period boundary is tick && pwm_cnt==255.
  - The shadow brightness loads from brightness only at a period boundary, so duty changes never glitch mid-period.
- Duty rule per channel:
  - on_i = leds_val[i] && enable && (duty==8'hFF || pwm_cnt < duty), where duty = shadow brightness.
  - duty 0 means always off; duty 8'hFF means always on.
- led_pins is registered, so leds_val changes reach the pins with one clk of latency.
- Disable (enable==0):
  - Prescaler and pwm_cnt are held at 0; the shadow loads brightness every cycle.
  - led_pins go to 0 on the cycle after the write takes effect.
  - On re-enable, a fresh period starts at pwm_cnt=0.
- Simultaneous brightness write and period boundary: the shadow loads the old value; the new value applies at the following boundary.

Optional Feature:
- Macro: LEDS_PWM_FADE_EN.
- Defined:
  - Each channel keeps an 8-bit level.
  - At each period boundary, level moves one step toward its target: duty if leds_val[i], else 0.
  - The compare uses level in place of duty. level==8'hFF means always on; level==0 means always off.
  - Levels clear to 0 on reset and while disabled.
  - Result: LEDs ramp on and off over up to 255 periods.
- Not defined: no level registers; the duty rule above applies directly and leds_val edges reach the pins in one cycle.

Decomposition:
- Package leds_pkg holds:
  - The duty width constant (8).
  - Control-word bit positions: BRIGHT_LSB=0, BRIGHT_MSB=7, ENABLE_BIT=8.
  - The reset value of the control word (16'h01FF).
- Sub-module leds_pwm_channel:
  - One instance per LED via a generate loop.
  - Inputs: clk, reset, on request, duty, pwm_cnt, boundary, enable.
  - Holds the optional fade level and the pin register.

Test Plan (PRESCALE_DIV=2, NUM_LEDS=8):
- Reset held for 2 clk, then read with cs=1 → ack 1 cycle later, data_m_data_out=16'h01FF, led_pins=8'h00.
- leds_val=8'h05 with default brightness → led_pins=8'h05 from the next cycle, constant for a full 512-clk period.
- Write 16'h0040, bytesel=2'b01 mid-period → old duty persists until the boundary; then pin bit0 is high for 128 of every 512 clks, starting at the period start.
- Write brightness 8'h00 → after the next boundary, led_pins=8'h00 continuously while leds_val=8'hFF.
- Write 16'h0000, bytesel=2'b10 → led_pins=0 on the next cycle; brightness readback unchanged; re-enable → pwm_cnt restarts at 0.
- Assert reset mid-period with brightness=8'h40 → led_pins=0 on the next cycle; readback returns 16'h01FF.

Source files
------------

// File: rtl/leds_pkg.sv
// Shared constants for the LED PWM driver: duty width, control-word layout
// and its reset value.
package leds_pkg;

    localparam int DUTY_W     = 8;
    localparam int BRIGHT_LSB = 0;
    localparam int BRIGHT_MSB = 7;
    localparam int ENABLE_BIT = 8;

    localparam logic [15:0]       CTRL_RESET = 16'h01FF;
    localparam logic [DUTY_W-1:0] DUTY_FULL  = 8'hFF;

    // Assemble the readable control word; unused upper bits read as zero.
    function automatic logic [15:0] ctrl_word(input logic [DUTY_W-1:0] bright,
                                              input logic              en);
        logic [15:0] w;
        w = 16'h0000;
        w[BRIGHT_MSB:BRIGHT_LSB] = bright;
        w[ENABLE_BIT]            = en;
        return w;
    endfunction

endpackage

// File: rtl/leds_pwm_channel.sv
// One LED channel: duty compare against the shared PWM counter and the
// registered pin. With LEDS_PWM_FADE_EN defined, a per-channel level ramps
// one step per PWM period toward its target and replaces duty in the compare.
import leds_pkg::*;

module leds_pwm_channel (
    input  logic              clk,
    input  logic              reset,
    input  logic              on_req,
    input  logic [DUTY_W-1:0] duty,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic              boundary,
    input  logic              enable,
    output logic              pin
);

    logic [DUTY_W-1:0] cmp;
    logic              lit;

`ifdef LEDS_PWM_FADE_EN
    logic [DUTY_W-1:0] level;
    logic [DUTY_W-1:0] target;

    assign target = on_req ? duty : '0;

    // Step the fade level toward its target once per PWM period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            level <= '0;
        end else if (!enable) begin
            level <= '0;
        end else if (boundary) begin
            if (level < target)
                level <= level + 1'b1;
            else if (level > target)
                level <= level - 1'b1;
        end
    end

    assign cmp = level;
    assign lit = enable && (cmp == DUTY_FULL || pwm_cnt < cmp);
`else
    assign cmp = duty;
    assign lit = on_req && enable && (cmp == DUTY_FULL || pwm_cnt < cmp);
`endif

    // Register the pin drive.
    always_ff @(posedge clk) begin
        if (!reset)
            pin <= 1'b0;
        else
            pin <= lit;
    end

endmodule

// File: rtl/leds_pwm_driver.sv
// LED pin driver with global PWM dimming and a bus-visible control word
// (brightness [7:0], enable [8]). Optional per-channel fading is built in
// when LEDS_PWM_FADE_EN is defined.
import leds_pkg::*;

module leds_pwm_driver #(
    parameter int NUM_LEDS     = 8,
    parameter int PRESCALE_DIV = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] leds_val,
    output logic [NUM_LEDS-1:0] led_pins,
    input  logic                cs,
    input  logic [15:0]         data_m_data_in,
    output logic [15:0]         data_m_data_out,
    input  logic                data_m_access,
    output logic                data_m_ack,
    input  logic                data_m_wr_en,
    input  logic [1:0]          data_m_bytesel
);

    localparam int PRE_W = $clog2(PRESCALE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [DUTY_W-1:0] brightness;
    logic [DUTY_W-1:0] shadow;
    logic              enable;
    logic [PRE_W-1:0]  prescaler;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              sel;
    logic              wr;
    logic              tick;
    logic              boundary;
    logic [NUM_LEDS-1:0] pin_q;
    logic              unused_bits;

    assign sel         = cs && data_m_access;
    assign wr          = sel && data_m_wr_en;
    assign tick        = (prescaler == PRE_LAST);
    assign boundary    = enable && tick && (pwm_cnt == DUTY_FULL);
    assign unused_bits = ^data_m_data_in[15:ENABLE_BIT+1];

    // Control register writes, byte-lane qualified.
    always_ff @(posedge clk) begin
        if (!reset) begin
            brightness <= CTRL_RESET[BRIGHT_MSB:BRIGHT_LSB];
            enable     <= CTRL_RESET[ENABLE_BIT];
        end else if (wr) begin
            if (data_m_bytesel[0])
                brightness <= data_m_data_in[BRIGHT_MSB:BRIGHT_LSB];
            if (data_m_bytesel[1])
                enable <= data_m_data_in[ENABLE_BIT];
        end
    end

    // Registered bus acknowledge and read data (pre-write control word).
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_m_ack      <= 1'b0;
            data_m_data_out <= 16'h0000;
        end else begin
            data_m_ack      <= sel;
            data_m_data_out <= sel ? ctrl_word(brightness, enable) : 16'h0000;
        end
    end

    // Prescaler and PWM step counter; both parked at zero while disabled so
    // re-enabling always starts a fresh period.
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Shadow duty only changes between periods so a write never glitches
    // the current period; it tracks brightness freely while disabled.
    always_ff @(posedge clk) begin
        if (!reset)
            shadow <= CTRL_RESET[BRIGHT_MSB:BRIGHT_LSB];
        else if (!enable || boundary)
            shadow <= brightness;
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        leds_pwm_channel u_ch (
            .clk      (clk),
            .reset    (reset),
            .on_req   (leds_val[i]),
            .duty     (shadow),
            .pwm_cnt  (pwm_cnt),
            .boundary (boundary),
            .enable   (enable),
            .pin      (pin_q[i])
        );
    end

    assign led_pins = pin_q;

endmodule
